// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply/divide unit with HI/LO registers
//
// Executes MULT/MULTU/DIV/DIVU over 32 iterations (one per clock) and MTHI/MTLO
// in a single edge. HI/LO feed the writeback mux for MFHI/MFLO.
//
// Build option: define MULDIV_DIV_EN to compile the restoring divider. When it
// is undefined, DIV/DIVU are treated as reserved ops and ignored.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous, active-high
//   start  in   1   request, sampled on rising edge
//   op     in   3   000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                   101 MTHI, 110 MTLO, 111 reserved
//   a      in  32   rs operand: multiplicand, dividend or MTHI/MTLO data
//   b      in  32   rt operand: multiplier or divisor
//   busy   out  1   iteration in progress, requests ignored
//   done   out  1   one-cycle pulse, HI/LO hold the new result
//   hi     out 32   HI register
//   lo     out 32   LO register

module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Request decode
  logic        can_accept;
  logic        is_iter_op;
  logic        is_move_op;
  logic        accept_iter;
  logic        accept_move;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Iteration state. acc holds {upper, lower} halves: for multiply the
  // partial product over the remaining multiplier bits, for divide the
  // partial remainder over the dividend/quotient bits.
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_lo;
  logic        last_iter;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;
  logic [63:0] step_next;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

`ifdef MULDIV_DIV_EN
  logic        is_div;
  logic        neg_hi;
  logic        div_zero;
  logic [31:0] dividend_raw;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] q_res;
  logic [31:0] r_res;
`endif

  always_comb begin
    is_iter_op = 1'b0;
    is_move_op = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: is_iter_op = 1'b1;
      OP_DIV, OP_DIVU:   is_iter_op = DIV_EN;
      OP_MTHI, OP_MTLO:  is_move_op = 1'b1;
      default: begin
        is_iter_op = 1'b0;
        is_move_op = 1'b0;
      end
    endcase
  end

  assign can_accept  = start && (state != RUN);
  assign accept_iter = can_accept && is_iter_op;
  assign accept_move = can_accept && is_move_op;

  // Signed ops work on magnitudes; 32'h80000000 negates to itself, which is
  // the correct unsigned magnitude.
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op && a[31];
  assign b_neg     = signed_op && b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;

  assign last_iter = (count == 5'd31);

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept_iter) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = accept_iter ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift-add multiply step: add multiplicand to the upper half when the
  // current multiplier LSB is set, then shift right keeping the carry.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    mul_res  = neg_lo ? (64'd0 - mul_next) : mul_next;
  end

`ifdef MULDIV_DIV_EN
  // Restoring divide step: shift the next dividend bit into the remainder,
  // trial-subtract the divisor, keep the difference when it does not borrow.
  // A zero divisor never borrows, so the iterations still run normally and
  // the final result is overridden below.
  always_comb begin
    div_diff = acc[63:31] - {1'b0, opnd};
    if (div_diff[32]) begin
      div_next = {acc[62:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
    q_res = neg_lo ? (32'd0 - div_next[31:0])  : div_next[31:0];
    r_res = neg_hi ? (32'd0 - div_next[63:32]) : div_next[63:32];
  end

  always_comb begin
    step_next = is_div ? div_next : mul_next;
    if (!is_div) begin
      res_hi = mul_res[63:32];
      res_lo = mul_res[31:0];
    end else if (div_zero) begin
      res_hi = dividend_raw;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = r_res;
      res_lo = q_res;
    end
  end
`else
  always_comb begin
    step_next = mul_next;
    res_hi    = mul_res[63:32];
    res_lo    = mul_res[31:0];
  end
`endif

  // Datapath and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= 5'd0;
      acc          <= 64'd0;
      opnd         <= 32'd0;
      neg_lo       <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
`ifdef MULDIV_DIV_EN
      is_div       <= 1'b0;
      neg_hi       <= 1'b0;
      div_zero     <= 1'b0;
      dividend_raw <= 32'd0;
`endif
    end else begin
      if (accept_iter) begin
        count  <= 5'd0;
        neg_lo <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
        is_div       <= (op == OP_DIV) || (op == OP_DIVU);
        neg_hi       <= a_neg;
        div_zero     <= (b == 32'd0);
        dividend_raw <= a;
        if ((op == OP_DIV) || (op == OP_DIVU)) begin
          acc  <= {32'd0, a_mag};
          opnd <= b_mag;
        end else begin
          acc  <= {32'd0, b_mag};
          opnd <= a_mag;
        end
`else
        acc  <= {32'd0, b_mag};
        opnd <= a_mag;
`endif
      end else if (state == RUN) begin
        acc   <= step_next;
        count <= count + 5'd1;
        if (last_iter) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end

      if (accept_move) begin
        if (op == OP_MTHI) begin
          hi <= a;
        end else begin
          lo <= a;
        end
      end
    end
  end

endmodule
